// File: rtl/player_laser_ctrl.sv
// player_laser_ctrl: single player laser slot -- spawn on fire edge, paced upward flight, retire on hit/top, cooldown
module player_laser_ctrl #(
    parameter int tick_div_p = 250000,
    parameter int speed_p    = 8,
    parameter int top_p      = 16,
    parameter int spawn_y_p  = 440,
    parameter int cooldown_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       fire_i,
    input  logic [9:0] gun_pos_i,
    input  logic       freeze_i,
    input  logic       clear_i,
    input  logic       hit_i,
    output logic       laser_active_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_y_o,
    output logic       spawn_o,
    output logic [7:0] shots_o,
    output logic [2:0] state_o
);
    localparam int tw_c = tick_div_p > 1 ? $clog2(tick_div_p) : 1;
    localparam int cw_c = $clog2(cooldown_p + 2);
    typedef enum logic [2:0] {IDLE = 3'b001, FLYING = 3'b010, COOLDOWN = 3'b100} state_t;
    state_t state, state_n;
    logic [tw_c-1:0] tick_cnt;
    logic [cw_c-1:0] cd, cd_n;
    logic [9:0] x, y, x_n, y_n;
    logic [7:0] shots, shots_n;
    logic spawn, spawn_n, fire_q, tick, fire_edge;
    assign tick      = !freeze_i && tick_cnt == tw_c'(tick_div_p - 1);
    assign fire_edge = fire_i & ~fire_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            tick_cnt <= '0;
            cd       <= '0;
            x        <= '0;
            y        <= '0;
            shots    <= '0;
            spawn    <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= freeze_i ? tick_cnt : (tick ? '0 : tick_cnt + 1'b1);
            cd       <= cd_n;
            x        <= x_n;
            y        <= y_n;
            shots    <= shots_n;
            spawn    <= spawn_n;
            fire_q   <= fire_i;
        end
    end
    // freeze gates every transition; clear and illegal encodings fall back to IDLE regardless
    always_comb begin
        state_n = state;
        cd_n    = cd;
        x_n     = x;
        y_n     = y;
        shots_n = shots;
        spawn_n = 1'b0;
        if (clear_i) state_n = IDLE;
        else case (state)
            IDLE: if (!freeze_i && fire_edge) begin
                state_n = FLYING;
                x_n     = gun_pos_i;
                y_n     = 10'(spawn_y_p);
                shots_n = shots + 8'(shots != 8'hff);
                spawn_n = 1'b1;
            end
            FLYING: if (!freeze_i && hit_i) begin
                state_n = COOLDOWN;
                cd_n    = cw_c'(cooldown_p);
            end else if (tick) begin
                if ({1'b0, y} < 11'(top_p + speed_p)) begin
                    state_n = COOLDOWN;
                    cd_n    = cw_c'(cooldown_p);
                end else y_n = y - 10'(speed_p);
            end
            COOLDOWN: if (!freeze_i && cd == '0) state_n = IDLE;
                else if (tick) cd_n = cd - 1'b1;
            default: state_n = IDLE;
        endcase
    end
    assign laser_active_o = state == FLYING;
    assign laser_x_o      = x;
    assign laser_y_o      = y;
    assign spawn_o        = spawn;
    assign shots_o        = shots;
    assign state_o        = state;
endmodule

// File: tb/tb_player_laser_ctrl.sv
// tb_player_laser_ctrl: directed test-plan scenarios plus random stimulus against a behavioural laser model
module tb_player_laser_ctrl;
    localparam int div_c = 4, spd_c = 8, top_c = 16, sy_c = 440, cdp_c = 2;
    logic clk = 1'b0, reset = 1'b0, fire = 1'b0, freeze = 1'b0, clear = 1'b0, hit = 1'b0;
    logic [9:0] gun = '0;
    logic active, spawn;
    logic [9:0] lx, ly;
    logic [7:0] shots;
    logic [2:0] st;
    int n_vec = 0, n_err = 0;
    // model: mode 0 idle, 1 flying, 2 cooldown; run counts unfrozen cycles since reset
    int m_mode = 0, m_x = 0, m_y = 0, m_shots = 0, m_run = 0, m_cd = 0, s0 = 0, y0 = 0;
    bit m_spawn = 0, m_fire = 0;

    player_laser_ctrl #(.tick_div_p(div_c), .speed_p(spd_c), .top_p(top_c),
                        .spawn_y_p(sy_c), .cooldown_p(cdp_c)) dut (
        .clk_i(clk), .reset_i(reset), .fire_i(fire), .gun_pos_i(gun), .freeze_i(freeze),
        .clear_i(clear), .hit_i(hit), .laser_active_o(active), .laser_x_o(lx),
        .laser_y_o(ly), .spawn_o(spawn), .shots_o(shots), .state_o(st));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model();
        bit tk, edge_seen;
        tk = !freeze && (m_run % div_c == div_c - 1);
        edge_seen = fire && !m_fire;
        m_spawn = 0;
        if (reset) begin
            m_mode = 0; m_x = 0; m_y = 0; m_shots = 0; m_run = 0; m_cd = 0; m_fire = 0;
        end else begin
            m_fire = fire;
            if (!freeze) m_run++;
            if (clear) m_mode = 0;
            else if (!freeze) begin
                if (m_mode == 0 && edge_seen) begin
                    m_mode = 1; m_x = gun; m_y = sy_c; m_spawn = 1;
                    m_shots = m_shots < 255 ? m_shots + 1 : 255;
                end else if (m_mode == 1 && (hit || (tk && m_y < top_c + spd_c))) begin
                    m_mode = 2; m_cd = cdp_c;
                end else if (m_mode == 1 && tk) m_y -= spd_c;
                else if (m_mode == 2 && m_cd == 0) m_mode = 0;
                else if (m_mode == 2 && tk) m_cd--;
            end
        end
    endtask

    task automatic cyc(input logic f, input logic fz, input logic h, input logic c, input logic r);
        fire = f; freeze = fz; hit = h; clear = c; reset = r;
        @(posedge clk);
        model();
        #1;
        check("state", st, 32'(1 << m_mode));
        check("active", active, m_mode == 1);
        check("x", lx, m_x);
        check("y", ly, m_y);
        check("spawn", spawn, m_spawn);
        check("shots", shots, m_shots);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("rst_state", st, 3'b001);
        check("rst_out", {active, spawn, lx, ly, shots}, 0);
        gun = 10'd245;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("spawn_pulse", spawn, 1);
        check("spawn_xy", {lx, ly}, {10'd245, 10'd440});
        check("spawn_shots", shots, 1);
        cyc(0, 0, 0, 0, 0);
        check("spawn_once", spawn, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
        check("y_4ticks", ly, 408);
        for (int i = 0; i < 400 && active; i++) cyc(0, 0, 0, 0, 0);
        check("expire_y", ly, top_c);
        check("expire_state", st, 3'b100);
        for (int i = 0; i < 50 && st != 3'b001; i++) cyc(0, 0, 0, 0, 0);
        check("cool_idle", st, 3'b001);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 400 && !(m_mode == 1 && m_y == 400 && m_run % div_c == div_c - 1); i++)
            cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("hit_active", active, 0);
        check("hit_y", ly, 400);
        check("hit_state", st, 3'b100);
        for (int i = 0; i < 50 && st != 3'b001; i++) cyc(0, 0, 0, 0, 0);
        s0 = m_shots;
        for (int i = 0; i < 500; i++) cyc(1, 0, 0, 0, 0);
        check("hold_shots", shots, 8'(s0 + 1));
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("refire_shots", shots, 8'(s0 + 2));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        y0 = m_y;
        for (int i = 0; i < 20; i++) cyc(0, 1, i == 10, 0, 0);
        check("frz_y", ly, 10'(y0));
        check("frz_active", active, 1);
        cyc(0, 0, 0, 1, 0);
        check("clr_state", st, 3'b001);
        check("clr_shots", shots, 8'(s0 + 2));
        for (int i = 0; i < 3000; i++) begin
            gun = 10'($urandom);
            cyc($urandom_range(0, 5) < 2 ? ~fire : fire, $urandom_range(0, 9) == 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
